fence_sequencer: RTL and testbench
==================================

FENCE_SEQUENCER -- requirements
Module: fence_sequencer

Interface
REQ-001 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have port hazard_signal  in  4  pipeline hazard code, using the team's FLUSH_EARLY, FLUSH_ALL and STALL_MMU encodings.
REQ-004 SHALL have port fence_req  in  1  decode stage holds a FENCE, FENCE.I or SFENCE.VMA.
REQ-005 SHALL have port fence_type  in  2  00 FENCE, 01 FENCE.I, 10 SFENCE.VMA; 11 treated as FENCE.
REQ-006 SHALL have port pipe_empty  in  1  no load or store pending in EX, MEM or WB.
REQ-007 SHALL have port sb_empty  in  1  store buffer drained.
REQ-008 SHALL have port tlb_flush_ack  in  1  TLB flush complete.
REQ-009 SHALL have port icache_inv_ack  in  1  instruction-cache invalidate complete.
REQ-010 SHALL have port fence_stall  out  1  hold the fetch and decode stages.
REQ-011 SHALL have port tlb_flush_req  out  1  level request to the TLB.
REQ-012 SHALL have port icache_inv_req  out  1  level request to the I-cache.
REQ-013 SHALL have port fence_done  out  1  one-cycle completion pulse.
REQ-014 SHALL have port fence_timeout  out  1  one-cycle watchdog pulse (see Configuration).

Function
REQ-015 SHALL implement the states IDLE, DRAIN, FLUSH_TLB, INV_ICACHE and DONE.
REQ-016 IDLE: on fence_req=1 with hazard_signal not STALL_MMU, SHALL latch fence_type and go to DRAIN.
REQ-017 DRAIN: when pipe_empty=1 and sb_empty=1 in the same cycle, SHALL go to DONE for FENCE, INV_ICACHE for FENCE.I, or FLUSH_TLB for SFENCE.VMA.
REQ-018 FLUSH_TLB/INV_ICACHE: SHALL assert the matching request from the first cycle in state until the cycle tlb_flush_ack/icache_inv_ack=1, then go to DONE on the next edge.
REQ-019 A request SHALL be registered and SHALL drop in the cycle after the ack is sampled; an ack arriving in the first request cycle is legal.
REQ-020 DONE: SHALL assert fence_done for exactly one cycle with fence_stall=0, then go to IDLE regardless of fence_req.
REQ-021 fence_stall SHALL equal (state in DRAIN, FLUSH_TLB or INV_ICACHE) OR (state=IDLE AND fence_req=1), combinationally.
REQ-022 Minimum latency: a FENCE with both empties high SHALL stall 2 cycles, with fence_done in cycle 3 counting from fence_req.
REQ-023 STALL_MMU SHALL freeze state, the latched type and the watchdog; request outputs SHALL hold their value.
REQ-024 FLUSH_EARLY or FLUSH_ALL in IDLE, DRAIN or DONE SHALL force IDLE on the next edge with no fence_done.
REQ-025 FLUSH_EARLY or FLUSH_ALL in FLUSH_TLB or INV_ICACHE SHALL set an abort flag; the handshake SHALL complete, then the block SHALL go to IDLE with no fence_done and clear the flag.
REQ-026 fence_stall SHALL be 0 in any cycle that carries FLUSH_EARLY or FLUSH_ALL.
REQ-027 fence_type changes after the transition out of IDLE SHALL be ignored.

Reset
REQ-028 rst=1 SHALL immediately force state IDLE, clear the abort flag, latched type and watchdog, and drive tlb_flush_req, icache_inv_req, fence_done and fence_timeout to 0.
REQ-029 Reset mid-handshake SHALL drop the request without waiting for the ack; a late ack after reset SHALL be ignored.

Configuration
REQ-030 With FENCE_WATCHDOG_EN defined, an 8-bit counter SHALL count cycles in DRAIN (cleared on entry, frozen on STALL_MMU).
REQ-031 With FENCE_WATCHDOG_EN defined, on reaching 255 the block SHALL pulse fence_timeout for one cycle and take the REQ-017 exit as if both empties were high.
REQ-032 Without FENCE_WATCHDOG_EN, there SHALL be no counter and fence_timeout SHALL be tied to 0; DRAIN waits indefinitely.

Verification
REQ-033 FENCE with pipe_empty=sb_empty=1 -> fence_stall high cycles 1-2, fence_done in cycle 3, then IDLE.
REQ-034 SFENCE.VMA with sb_empty rising at cycle 5 and tlb_flush_ack at cycle 9 -> tlb_flush_req high cycles 6-9, fence_done at cycle 10, icache_inv_req never set.
REQ-035 FENCE.I in INV_ICACHE with FLUSH_ALL at cycle 4 and ack at cycle 7 -> icache_inv_req held to cycle 7, IDLE at cycle 8, no fence_done.
REQ-036 STALL_MMU for 3 cycles while in DRAIN with empties high -> state frozen, exit 3 cycles later than without the stall.
REQ-037 FENCE_WATCHDOG_EN defined, sb_empty held 0 -> fence_timeout pulses after 255 DRAIN cycles, fence_done one cycle later; with the macro undefined, stall persists.
REQ-038 rst asserted during FLUSH_TLB -> tlb_flush_req=0 immediately, IDLE; a following ack produces no fence_done.

Source files
------------

// File: rtl/fence_if.sv
// Handshake bundle between the decode/memory pipeline and the fence sequencer.
interface fence_if;
  logic [3:0] hazard_signal;
  logic       fence_req;
  logic [1:0] fence_type;
  logic       pipe_empty;
  logic       sb_empty;
  logic       tlb_flush_ack;
  logic       icache_inv_ack;
  logic       fence_stall;
  logic       tlb_flush_req;
  logic       icache_inv_req;
  logic       fence_done;
  logic       fence_timeout;

  modport master (
    output hazard_signal, fence_req, fence_type, pipe_empty, sb_empty,
           tlb_flush_ack, icache_inv_ack,
    input  fence_stall, tlb_flush_req, icache_inv_req, fence_done, fence_timeout
  );

  modport slave (
    input  hazard_signal, fence_req, fence_type, pipe_empty, sb_empty,
           tlb_flush_ack, icache_inv_ack,
    output fence_stall, tlb_flush_req, icache_inv_req, fence_done, fence_timeout
  );
endinterface

// File: rtl/fence_sequencer.sv
// Sequences FENCE / FENCE.I / SFENCE.VMA: drain, optional TLB flush or I-cache invalidate, done pulse.
// Optional DRAIN watchdog enabled by defining FENCE_WATCHDOG_EN.
module fence_sequencer (
  input  logic   clk,
  input  logic   rst,
  fence_if.slave bus
);
  localparam logic [3:0] HZ_FLUSH_EARLY = 4'b0100;
  localparam logic [3:0] HZ_FLUSH_ALL   = 4'b0101;
  localparam logic [3:0] HZ_STALL_MMU   = 4'b1000;

  localparam logic [1:0] FT_FENCE_I = 2'b01;
  localparam logic [1:0] FT_SFENCE  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_DRAIN      = 3'd1,
    ST_FLUSH_TLB  = 3'd2,
    ST_INV_ICACHE = 3'd3,
    ST_DONE       = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] type_q, type_d;
  logic       abort_q, abort_d;
  logic       tlb_req_q, tlb_req_d;
  logic       ic_req_q, ic_req_d;

  logic flush_s;
  logic mmu_s;
  logic wd_expired_s;
  logic drain_ok_s;
  logic busy_s;

  assign flush_s    = (bus.hazard_signal == HZ_FLUSH_EARLY) || (bus.hazard_signal == HZ_FLUSH_ALL);
  assign mmu_s      = (bus.hazard_signal == HZ_STALL_MMU);
  assign drain_ok_s = (bus.pipe_empty && bus.sb_empty) || wd_expired_s;

`ifdef FENCE_WATCHDOG_EN
  logic [7:0] wd_q, wd_d;

  assign wd_expired_s      = (state_q == ST_DRAIN) && (wd_q == 8'd255);
  assign bus.fence_timeout = wd_expired_s && !mmu_s && !flush_s;

  // Watchdog counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q <= 8'd0;
    end else begin
      wd_q <= wd_d;
    end
  end

  // Counts DRAIN cycles; held at zero outside DRAIN so every entry starts fresh
  always_comb begin
    wd_d = wd_q;
    if (mmu_s) begin
      wd_d = wd_q;
    end else if (state_q != ST_DRAIN) begin
      wd_d = 8'd0;
    end else if (!wd_expired_s) begin
      wd_d = wd_q + 8'd1;
    end else begin
      wd_d = wd_q;
    end
  end
`else
  assign wd_expired_s      = 1'b0;
  assign bus.fence_timeout = 1'b0;
`endif

  // State, latched type, abort flag and request registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      type_q    <= 2'b00;
      abort_q   <= 1'b0;
      tlb_req_q <= 1'b0;
      ic_req_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      type_q    <= type_d;
      abort_q   <= abort_d;
      tlb_req_q <= tlb_req_d;
      ic_req_q  <= ic_req_d;
    end
  end

  // Next-state logic; STALL_MMU freezes everything, flushes abort or cancel
  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    abort_d = abort_q;
    if (mmu_s) begin
      state_d = state_q;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.fence_req && !flush_s) begin
            state_d = ST_DRAIN;
            type_d  = bus.fence_type;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (flush_s) begin
            state_d = ST_IDLE;
          end else if (drain_ok_s) begin
            case (type_q)
              FT_FENCE_I: state_d = ST_INV_ICACHE;
              FT_SFENCE:  state_d = ST_FLUSH_TLB;
              default:    state_d = ST_DONE;
            endcase
          end else begin
            state_d = ST_DRAIN;
          end
        end
        ST_FLUSH_TLB, ST_INV_ICACHE: begin
          // The handshake must finish even when aborted; the flag only suppresses the done pulse
          if ((state_q == ST_FLUSH_TLB) ? bus.tlb_flush_ack : bus.icache_inv_ack) begin
            state_d = (abort_q || flush_s) ? ST_IDLE : ST_DONE;
            abort_d = 1'b0;
          end else if (flush_s) begin
            abort_d = 1'b1;
          end else begin
            abort_d = abort_q;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          abort_d = 1'b0;
        end
      endcase
    end
    tlb_req_d = (state_d == ST_FLUSH_TLB);
    ic_req_d  = (state_d == ST_INV_ICACHE);
  end

  assign busy_s = (state_q == ST_DRAIN) || (state_q == ST_FLUSH_TLB) || (state_q == ST_INV_ICACHE);

  assign bus.fence_stall    = !flush_s && (busy_s || ((state_q == ST_IDLE) && bus.fence_req));
  assign bus.tlb_flush_req  = tlb_req_q;
  assign bus.icache_inv_req = ic_req_q;
  assign bus.fence_done     = (state_q == ST_DONE) && !flush_s && !mmu_s;
endmodule

// File: tb/tb_fence_sequencer.sv
// Directed bench for fence_sequencer; vectors are {hazard[4], req, type[2], pipe_empty, sb_empty, tlb_ack, ic_ack}
// and expected outputs are {fence_stall, tlb_flush_req, icache_inv_req, fence_done, fence_timeout}.
module tb_fence_sequencer;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  fence_if bus ();

  fence_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  wire [4:0] obs = {bus.fence_stall, bus.tlb_flush_req, bus.icache_inv_req,
                    bus.fence_done, bus.fence_timeout};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply(input logic [10:0] v);
    {bus.hazard_signal, bus.fence_req, bus.fence_type, bus.pipe_empty,
     bus.sb_empty, bus.tlb_flush_ack, bus.icache_inv_ack} = v;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply(11'b0000_0_00_11_00);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    n_checks++;
    if (obs !== 5'b00000) begin
      n_errors++;
      $display("FAIL reset_hold: got %b want %b", obs, 5'b00000);
    end
    @(negedge clk);
    rst = 1'b0;
    next_cycle();
    #2;
    n_checks++;
    if (obs !== 5'b00000) begin
      n_errors++;
      $display("FAIL reset_release: got %b want %b", obs, 5'b00000);
    end
    next_cycle();
  endtask

  task automatic test_fence_min();
    logic [10:0] vin [4] = '{11'b0000_1_00_11_00, 11'b0000_1_00_11_00,
                             11'b0000_0_00_11_00, 11'b0000_0_00_11_00};
    logic [4:0]  vexp [4] = '{5'b10000, 5'b10000, 5'b00010, 5'b00000};
    for (int i = 0; i < 4; i++) begin
      apply(vin[i]);
      #2;
      n_checks++;
      if (obs !== vexp[i]) begin
        n_errors++;
        $display("FAIL fence_min cyc%0d: got %b want %b", i + 1, obs, vexp[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_fence_types();
    // type 11 behaves as FENCE; FENCE.I with ack in the first request cycle
    logic [10:0] vin [9] = '{11'b0000_1_11_11_00, 11'b0000_1_11_11_00,
                             11'b0000_0_00_11_00, 11'b0000_0_00_11_00,
                             11'b0000_1_01_11_00, 11'b0000_1_01_11_00,
                             11'b0000_1_01_11_01, 11'b0000_0_00_11_00,
                             11'b0000_0_00_11_00};
    logic [4:0]  vexp [9] = '{5'b10000, 5'b10000, 5'b00010, 5'b00000,
                              5'b10000, 5'b10000, 5'b10100, 5'b00010, 5'b00000};
    for (int i = 0; i < 9; i++) begin
      apply(vin[i]);
      #2;
      n_checks++;
      if (obs !== vexp[i]) begin
        n_errors++;
        $display("FAIL fence_types cyc%0d: got %b want %b", i + 1, obs, vexp[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_sfence();
    logic [10:0] vin [11] = '{11'b0000_1_10_10_00, 11'b0000_1_10_10_00,
                              11'b0000_1_01_10_00, 11'b0000_1_00_10_00,
                              11'b0000_1_00_11_00, 11'b0000_1_00_11_00,
                              11'b0000_1_00_11_00, 11'b0000_1_00_11_00,
                              11'b0000_1_00_11_10, 11'b0000_0_00_11_00,
                              11'b0000_0_00_11_00};
    logic [4:0]  vexp [11] = '{5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b10000,
                               5'b11000, 5'b11000, 5'b11000, 5'b11000,
                               5'b00010, 5'b00000};
    for (int i = 0; i < 11; i++) begin
      apply(vin[i]);
      #2;
      n_checks++;
      if (obs !== vexp[i]) begin
        n_errors++;
        $display("FAIL sfence cyc%0d: got %b want %b", i + 1, obs, vexp[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_abort_inv();
    logic [10:0] vin [9] = '{11'b0000_1_01_11_00, 11'b0000_1_01_11_00,
                             11'b0000_1_01_11_00, 11'b0101_0_00_11_00,
                             11'b0000_0_00_11_00, 11'b0000_0_00_11_00,
                             11'b0000_0_00_11_01, 11'b0000_0_00_11_00,
                             11'b0000_0_00_11_00};
    logic [4:0]  vexp [9] = '{5'b10000, 5'b10000, 5'b10100, 5'b00100, 5'b10100,
                              5'b10100, 5'b10100, 5'b00000, 5'b00000};
    for (int i = 0; i < 9; i++) begin
      apply(vin[i]);
      #2;
      n_checks++;
      if (obs !== vexp[i]) begin
        n_errors++;
        $display("FAIL abort_inv cyc%0d: got %b want %b", i + 1, obs, vexp[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_stall_mmu();
    logic [10:0] vin [14] = '{11'b0000_1_00_11_00, 11'b1000_1_00_11_00,
                              11'b1000_1_00_11_00, 11'b1000_1_00_11_00,
                              11'b0000_1_00_11_00, 11'b0000_0_00_11_00,
                              11'b0000_0_00_11_00,
                              11'b0000_1_10_11_00, 11'b0000_1_10_11_00,
                              11'b0000_1_10_11_00, 11'b1000_1_10_11_00,
                              11'b0000_1_10_11_10, 11'b0000_0_00_11_00,
                              11'b0000_0_00_11_00};
    logic [4:0]  vexp [14] = '{5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b10000,
                               5'b00010, 5'b00000,
                               5'b10000, 5'b10000, 5'b11000, 5'b11000, 5'b11000,
                               5'b00010, 5'b00000};
    for (int i = 0; i < 14; i++) begin
      apply(vin[i]);
      #2;
      n_checks++;
      if (obs !== vexp[i]) begin
        n_errors++;
        $display("FAIL stall_mmu cyc%0d: got %b want %b", i + 1, obs, vexp[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_flush();
    // flush in DRAIN, flush in IDLE with a request, flush in DONE
    logic [10:0] vin [11] = '{11'b0000_1_00_10_00, 11'b0000_1_00_10_00,
                              11'b0100_1_00_10_00, 11'b0000_0_00_11_00,
                              11'b0100_1_00_11_00, 11'b0000_0_00_11_00,
                              11'b0000_1_00_11_00, 11'b0000_1_00_11_00,
                              11'b0101_0_00_11_00, 11'b0000_0_00_11_00,
                              11'b0000_0_00_11_00};
    logic [4:0]  vexp [11] = '{5'b10000, 5'b10000, 5'b00000, 5'b00000, 5'b00000,
                               5'b00000, 5'b10000, 5'b10000, 5'b00000, 5'b00000,
                               5'b00000};
    for (int i = 0; i < 11; i++) begin
      apply(vin[i]);
      #2;
      n_checks++;
      if (obs !== vexp[i]) begin
        n_errors++;
        $display("FAIL flush cyc%0d: got %b want %b", i + 1, obs, vexp[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] vin [3] = '{11'b0000_1_10_11_00, 11'b0000_1_10_11_00,
                             11'b0000_1_10_11_00};
    logic [4:0]  vexp [3] = '{5'b10000, 5'b10000, 5'b11000};
    for (int i = 0; i < 3; i++) begin
      apply(vin[i]);
      #2;
      n_checks++;
      if (obs !== vexp[i]) begin
        n_errors++;
        $display("FAIL reset_mid cyc%0d: got %b want %b", i + 1, obs, vexp[i]);
      end
      if (i < 2) next_cycle();
    end
    #1;
    rst = 1'b1;
    bus.fence_req = 1'b0;
    #1;
    n_checks++;
    if (obs !== 5'b00000) begin
      n_errors++;
      $display("FAIL reset_mid async: got %b want %b", obs, 5'b00000);
    end
    next_cycle();
    rst = 1'b0;
    apply(11'b0000_0_00_11_10);
    #2;
    n_checks++;
    if (obs !== 5'b00000) begin
      n_errors++;
      $display("FAIL reset_mid late_ack: got %b want %b", obs, 5'b00000);
    end
    next_cycle();
    apply(11'b0000_0_00_11_00);
    #2;
    n_checks++;
    if (obs !== 5'b00000) begin
      n_errors++;
      $display("FAIL reset_mid after: got %b want %b", obs, 5'b00000);
    end
    next_cycle();
  endtask

  task automatic test_watchdog();
    logic [4:0] want;
    apply(11'b0000_1_00_10_00);
    #2;
    n_checks++;
    if (obs !== 5'b10000) begin
      n_errors++;
      $display("FAIL watchdog start: got %b want %b", obs, 5'b10000);
    end
    next_cycle();
`ifdef FENCE_WATCHDOG_EN
    for (int k = 1; k <= 256; k++) begin
      want = (k == 256) ? 5'b10001 : 5'b10000;
      #2;
      n_checks++;
      if (obs !== want) begin
        n_errors++;
        $display("FAIL watchdog drain%0d: got %b want %b", k, obs, want);
      end
      next_cycle();
    end
    apply(11'b0000_0_00_10_00);
    #2;
    n_checks++;
    if (obs !== 5'b00010) begin
      n_errors++;
      $display("FAIL watchdog done: got %b want %b", obs, 5'b00010);
    end
    next_cycle();
`else
    want = 5'b10000;
    for (int k = 1; k <= 300; k++) begin
      #2;
      n_checks++;
      if (obs !== want) begin
        n_errors++;
        $display("FAIL watchdog hold%0d: got %b want %b", k, obs, want);
      end
      next_cycle();
    end
    apply(11'b0101_0_00_10_00);
    #2;
    n_checks++;
    if (obs !== 5'b00000) begin
      n_errors++;
      $display("FAIL watchdog flush: got %b want %b", obs, 5'b00000);
    end
    next_cycle();
`endif
    apply(11'b0000_0_00_11_00);
    #2;
    n_checks++;
    if (obs !== 5'b00000) begin
      n_errors++;
      $display("FAIL watchdog idle: got %b want %b", obs, 5'b00000);
    end
    next_cycle();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    test_reset();
    test_fence_min();
    test_fence_types();
    test_sfence();
    test_abort_inv();
    test_stall_mmu();
    test_flush();
    test_reset_mid();
    test_watchdog();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
